// File: rtl/ram_program_loader.sv
// ram_program_loader
//
// Streams a framed, checksummed program image into the CPU's RAM and keeps
// the CPU in reset until the whole frame has been received and validated.
//
// Frame: SYNC_BYTE, LEN, LEN data bytes, CHK.
//   LEN = 0 means a full RAM (DEPTH bytes); LEN > DEPTH aborts the frame.
//   The frame is good when (sum of data bytes + CHK) mod 2**DATA_WIDTH == 0.
//
// Ports:
//   clk         system clock, all logic on its rising edge
//   reset       synchronous, active-low reset
//   in_data     stream byte
//   in_valid    in_data is valid
//   in_ready    loader accepts a byte this cycle (low only while in reset)
//   ram_we      registered RAM write strobe, one cycle per data byte
//   ram_addr    registered RAM write address
//   ram_wdata   registered RAM write data
//   cpu_hold    high = CPU held in reset
//   load_done   sticky, last frame validated
//   load_error  sticky, last frame failed
module ram_program_loader #(
   parameter int          DATA_WIDTH    = 8,
   parameter int          ADDR_WIDTH    = 4,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   parameter bit          HOLD_AT_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  load_error
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   // One extra bit so a full-depth count is representable and the index
   // reaches DEPTH without wrapping back onto address 0.
   localparam int IW    = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   state_t                state_reg, state_next;
   logic                  ready_reg;
   logic                  we_reg, we_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
   logic                  hold_reg, hold_next;
   logic                  done_reg, done_next;
   logic                  error_reg, error_next;
   logic [IW-1:0]         idx_reg, idx_next;
   logic [IW-1:0]         count_reg, count_next;
   logic [DATA_WIDTH-1:0] acc_reg, acc_next;

   logic                  xfer;
   logic [DATA_WIDTH-1:0] chk_sum;
   logic [IW-1:0]         idx_inc;

   assign in_ready   = ready_reg;
   assign ram_we     = we_reg;
   assign ram_addr   = addr_reg;
   assign ram_wdata  = wdata_reg;
   assign cpu_hold   = hold_reg;
   assign load_done  = done_reg;
   assign load_error = error_reg;

   assign xfer    = in_valid && ready_reg;
   assign chk_sum = acc_reg + in_data;
   assign idx_inc = idx_reg + IW'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= S_IDLE;
         ready_reg <= 1'b0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         hold_reg  <= HOLD_AT_RESET;
         done_reg  <= 1'b0;
         error_reg <= 1'b0;
         idx_reg   <= '0;
         count_reg <= '0;
         acc_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ready_reg <= 1'b1;
         we_reg    <= we_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         hold_reg  <= hold_next;
         done_reg  <= done_next;
         error_reg <= error_next;
         idx_reg   <= idx_next;
         count_reg <= count_next;
         acc_reg   <= acc_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      we_next    = 1'b0;          // strobe only in the cycle after a data byte
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      hold_next  = hold_reg;
      done_next  = done_reg;
      error_next = error_reg;
      idx_next   = idx_reg;
      count_next = count_reg;
      acc_next   = acc_reg;

      case (state_reg)
         S_IDLE, S_DONE, S_ERR: begin
            // Only a header byte starts a frame; anything else is dropped.
            if (xfer && in_data == DATA_WIDTH'(SYNC_BYTE)) begin
               state_next = S_LEN;
               done_next  = 1'b0;
               error_next = 1'b0;
               hold_next  = 1'b1;
               idx_next   = '0;
               acc_next   = '0;
            end
         end

         S_LEN: begin
            if (xfer) begin
               if (in_data == '0) begin
                  count_next = IW'(DEPTH);
                  state_next = S_DATA;
               end else if (in_data > DATA_WIDTH'(DEPTH)) begin
                  // Oversized image: fail the frame before touching RAM.
                  state_next = S_ERR;
                  error_next = 1'b1;
               end else begin
                  count_next = IW'(in_data);
                  state_next = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (xfer) begin
               we_next    = 1'b1;
               addr_next  = idx_reg[ADDR_WIDTH-1:0];
               wdata_next = in_data;
               acc_next   = chk_sum;
               idx_next   = idx_inc;
               if (idx_inc == count_reg) begin
                  state_next = S_CHK;
               end
            end
         end

         S_CHK: begin
            if (xfer) begin
               if (chk_sum == '0) begin
                  state_next = S_DONE;
                  done_next  = 1'b1;
                  hold_next  = 1'b0;
               end else begin
                  // Partial image stays in RAM; the CPU remains held.
                  state_next = S_ERR;
                  error_next = 1'b1;
               end
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ram_program_loader.sv
// Directed testbench for ram_program_loader: framed loads, checksum failure
// and recovery, full-depth and oversized LEN, garbage and in_valid gaps,
// mid-frame reset, and a sync-valued data byte.
module tb_ram_program_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       ram_we;
   logic [3:0] ram_addr;
   logic [7:0] ram_wdata;
   logic       cpu_hold;
   logic       load_done;
   logic       load_error;

   ram_program_loader dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] img    [16];
   logic [7:0] tb_ram [16];
   logic [3:0] wa_q [$];
   logic [7:0] wd_q [$];

   // Capture every write strobe away from the active edge.
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         wa_q.push_back(ram_addr);
         wd_q.push_back(ram_wdata);
         tb_ram[ram_addr] = ram_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic set_image10();
      logic [7:0] v [10];
      v = '{8'h1F, 8'h2E, 8'h76, 8'h51, 8'h7A, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 10; i++) img[i] = v[i];
   endtask

   // Sends a whole frame, checks the header-edge flags, the last write strobe
   // lining up with the CHK cycle, and the exact write sequence.
   task automatic send_frame(input string tag, input logic [7:0] len, input int n,
                             input logic [7:0] chkb, input bit gaps);
      int base;
      base = wa_q.size();
      send(8'hA5);
      chk({tag, "/hdr_hold"},  {31'd0, cpu_hold},   32'd1);
      chk({tag, "/hdr_done"},  {31'd0, load_done},  32'd0);
      chk({tag, "/hdr_error"}, {31'd0, load_error}, 32'd0);
      send(len);
      for (int i = 0; i < n; i++) begin
         send(img[i]);
         if (gaps && i < n - 1) begin
            for (int g = 0; g <= i % 3; g++) begin
               cyc();
               chk({tag, "/gap_we"}, {31'd0, ram_we}, 32'd0);
            end
         end
      end
      chk({tag, "/last_we"},   {31'd0, ram_we},   32'd1);
      chk({tag, "/last_addr"}, {28'd0, ram_addr}, 32'(n - 1));
      send(chkb);
      chk({tag, "/nwrites"}, 32'(wa_q.size() - base), 32'(n));
      for (int i = 0; i < n; i++) begin
         chk({tag, "/waddr"}, {28'd0, wa_q[base + i]}, 32'(i));
         chk({tag, "/wdata"}, {24'd0, wd_q[base + i]}, {24'd0, img[i]});
      end
   endtask

   task automatic chk_good(input string tag);
      chk({tag, "/done"},  {31'd0, load_done},  32'd1);
      chk({tag, "/error"}, {31'd0, load_error}, 32'd0);
      chk({tag, "/hold"},  {31'd0, cpu_hold},   32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "/in_ready"},  {31'd0, in_ready},   32'd0);
      chk({tag, "/ram_we"},    {31'd0, ram_we},     32'd0);
      chk({tag, "/ram_addr"},  {28'd0, ram_addr},   32'd0);
      chk({tag, "/ram_wdata"}, {24'd0, ram_wdata},  32'd0);
      chk({tag, "/done"},      {31'd0, load_done},  32'd0);
      chk({tag, "/error"},     {31'd0, load_error}, 32'd0);
      chk({tag, "/hold"},      {31'd0, cpu_hold},   32'd1);
   endtask

   initial begin
      int base;

      // Reset state
      reset = 1'b0;
      cyc();
      cyc();
      chk_reset_outputs("rst");
      reset = 1'b1;
      cyc();
      chk("rst_release/in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_release/hold",     {31'd0, cpu_hold}, 32'd1);

      // 10-byte image, checksum 0x100 - 0x5E = 0xA2
      set_image10();
      send_frame("img10", 8'd10, 10, 8'hA2, 1'b0);
      chk_good("img10");
      for (int i = 0; i < 10; i++)
         chk("img10/ram", {24'd0, tb_ram[i]}, {24'd0, img[i]});

      // Bad checksum, then recovery
      send_frame("badchk", 8'd10, 10, 8'hA3, 1'b0);
      chk("badchk/error", {31'd0, load_error}, 32'd1);
      chk("badchk/done",  {31'd0, load_done},  32'd0);
      chk("badchk/hold",  {31'd0, cpu_hold},   32'd1);
      send_frame("resend", 8'd10, 10, 8'hA2, 1'b0);
      chk_good("resend");

      // LEN=0 -> 16 bytes 0x00..0x0F, sum 0x78, CHK 0x88
      for (int i = 0; i < 16; i++) img[i] = 8'(i);
      send_frame("full", 8'h00, 16, 8'h88, 1'b0);
      chk_good("full");
      base = wa_q.size();
      cyc();
      cyc();
      chk("full/no_wrap_write", 32'(wa_q.size() - base), 32'd0);

      // LEN=0x11 -> error on LEN edge, no writes afterwards
      base = wa_q.size();
      send(8'hA5);
      send(8'h11);
      chk("len17/error", {31'd0, load_error}, 32'd1);
      chk("len17/done",  {31'd0, load_done},  32'd0);
      chk("len17/hold",  {31'd0, cpu_hold},   32'd1);
      send(8'h00);
      send(8'h01);
      cyc();
      chk("len17/nwrites", 32'(wa_q.size() - base), 32'd0);

      // Garbage before header, in_valid gaps inside DATA
      base = wa_q.size();
      send(8'h00);
      send(8'hFF);
      send(8'h3C);
      cyc();
      chk("garbage/nwrites", 32'(wa_q.size() - base), 32'd0);
      chk("garbage/error",   {31'd0, load_error}, 32'd1);
      set_image10();
      send_frame("gaps", 8'd10, 10, 8'hA2, 1'b1);
      chk_good("gaps");

      // Reset after 3 of 10 data bytes
      base = wa_q.size();
      send(8'hA5);
      send(8'd10);
      send(img[0]);
      send(img[1]);
      send(img[2]);
      reset = 1'b0;
      cyc();
      chk("midrst/nwrites", 32'(wa_q.size() - base), 32'd3);
      chk_reset_outputs("midrst");
      reset = 1'b1;
      cyc();
      cyc();
      chk("midrst/quiet", 32'(wa_q.size() - base), 32'd3);
      send_frame("after_rst", 8'd10, 10, 8'hA2, 1'b0);
      chk_good("after_rst");

      // Sync-valued data byte: 0xA5+0x01+0x02 = 0xA8, CHK 0x58
      img[0] = 8'hA5;
      img[1] = 8'h01;
      img[2] = 8'h02;
      send_frame("sync_data", 8'd3, 3, 8'h58, 1'b0);
      chk_good("sync_data");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
